// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op_e    : MULT/MULTU/DIV/DIVU encodings as presented on the Op port
//   - state_e : sequencer states (IDLE, CALC, FIX)
//   - ITER    : radix-2 steps per operation at the default width
//   - CNT_W   : iteration counter width at the default width
//   - cnt_width(): counter width for any operand width
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int ITER      = DEF_WIDTH;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: combinational two's-complement negation.
//   value   in  W  operand
//   negated out W  (-value) modulo 2^W
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] negated
);

    assign negated = ~value + W'(1);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the MIPS execute stage.
// Operands are made non-negative at launch, WIDTH radix-2 steps run in CALC,
// and signs are restored in FIX when HI/LO are written.
//   Clk      in   rising-edge clock
//   Rst      in   synchronous active-high reset
//   Start    in   launch request, sampled only in IDLE
//   Op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Flush    in   cancel the in-flight operation
//   Rs_data  in   multiplicand / dividend
//   Rt_data  in   multiplier / divisor
//   Busy     out  operation in flight (registered)
//   Done     out  one-cycle pulse when HI/LO update
//   HI       out  product high half / remainder
//   LO       out  product low half / quotient
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Rs_data,
    input  logic [WIDTH-1:0] Rt_data,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = cnt_width(WIDTH);

    state_e             state;
    op_e                op_q;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [WIDTH-1:0]   rs_raw;
    logic [WIDTH-1:0]   opa;       // |multiplicand| or shifting |dividend|
    logic [WIDTH-1:0]   opb;       // shifting |multiplier| or |divisor|
    logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
    logic [CW-1:0]      cnt;

    // ---------------- launch: absolute values for signed ops ----------------
    logic             start_signed;
    logic [WIDTH-1:0] rs_neg, rt_neg, rs_abs, rt_abs;

    assign start_signed = ~Op[0];

    muldiv_negate #(.W(WIDTH)) u_neg_rs (.value(Rs_data), .negated(rs_neg));
    muldiv_negate #(.W(WIDTH)) u_neg_rt (.value(Rt_data), .negated(rt_neg));

    assign rs_abs = (start_signed && Rs_data[WIDTH-1]) ? rs_neg : Rs_data;
    assign rt_abs = (start_signed && Rt_data[WIDTH-1]) ? rt_neg : Rt_data;

    // ---------------- one radix-2 step ----------------
    logic             is_div;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign mul_addend = opb[0] ? opa : {WIDTH{1'b0}};
    // Carry out of the high half becomes the MSB after the right shift.
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Restoring divide: the shifted remainder can reach WIDTH+1 bits, but the
    // difference always fits WIDTH bits whenever the subtraction is kept.
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, opb};
    assign rem_sub = rem_sh[WIDTH-1:0] - opb;

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_neg, rem_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.value(acc), .negated(prod_neg));
    muldiv_negate #(.W(WIDTH)) u_neg_quo (.value(acc[WIDTH-1:0]), .negated(quo_neg));
    muldiv_negate #(.W(WIDTH)) u_neg_rem (.value(acc[2*WIDTH-1:WIDTH]), .negated(rem_neg));

    // NOTE: every output of this block gets a default first, so no path
    // through the branches can leave one unassigned and infer a latch.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? prod_neg : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = rs_raw;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = sign_a ? rem_neg : acc[2*WIDTH-1:WIDTH];
                fix_lo = (sign_a ^ sign_b) ? quo_neg : acc[WIDTH-1:0];
            end
        end
    end

    // ---------------- sequencer and state ----------------
    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            op_q     <= OP_MULT;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            rs_raw   <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        op_q     <= op_e'(Op);
                        sign_a   <= start_signed && Rs_data[WIDTH-1];
                        sign_b   <= start_signed && Rt_data[WIDTH-1];
                        div_zero <= Op[1] && (Rt_data == '0);
                        rs_raw   <= Rs_data;
                        opa      <= rs_abs;
                        opb      <= rt_abs;
                        acc      <= '0;
                        cnt      <= '0;
                        Busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (Flush) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]),
                                    acc[WIDTH-2:0], rem_ge};
                            opa <= opa << 1;
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                            opb <= opb >> 1;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!Flush) begin
                        HI   <= fix_hi;
                        LO   <= fix_lo;
                        Done <= 1'b1;
                    end
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the execute stage of the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU operands from the ID/EXE register, computes over WIDTH+2 cycles, and writes the HI/LO pair that MFHI/MFLO read through the register-file HI/LO path. Busy feeds the hazard detection unit so later HI/LO readers and new mul/div ops stall until the result is committed.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Start  in  1  launch request, sampled only in IDLE
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- Flush  in  1  cancel in-flight operation (branch/exception flush)
- Rs_data  in  WIDTH  multiplicand / dividend, already forwarded
- Rt_data  in  WIDTH  multiplier / divisor, already forwarded
- Busy  out  WIDTH-independent 1  operation in flight; drives the stall path
- Done  out  1  one-cycle pulse when HI/LO update
- HI  out  WIDTH  product high half / remainder
- LO  out  WIDTH  product low half / quotient

## Operation
- States: IDLE, CALC, FIX.
- IDLE: Start=1 and Flush=0 -> latch Op, sign flags, |Rs_data|, |Rt_data| (absolute values only for MULT/DIV; MULTU/DIVU use raw bits), clear 2·WIDTH accumulator, iteration counter=0, go CALC.
- CALC: one radix-2 step per cycle. Multiply: shift-add on the LSB of the multiplier. Divide: restoring, shift remainder left, subtract divisor, set quotient bit if non-negative. Counter increments; after the step with counter=WIDTH-1, go FIX.
- FIX: apply signs, write HI/LO, pulse Done, go IDLE.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^(2·WIDTH) for products and 2^WIDTH for quotient/remainder. DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (Rt_data=0, DIV or DIVU): runs the full latency; result LO=all-ones, HI=Rs_data (unmodified input), with no sign fix.
- Start while Busy: ignored, not queued.
- Flush in CALC or FIX: return to IDLE next edge; HI/LO keep their previous values; no Done.
- Start and Flush in the same IDLE cycle: Flush wins; no launch.
- HI/LO hold their values between operations; they change only in FIX.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0.
- Start is sampled high at edge N:
  - Busy=1 from after edge N through after edge N+WIDTH.
  - FIX occupies the cycle after edge N+WIDTH.
  - HI/LO update and Done=1 take effect after edge N+WIDTH+1; Busy=0 in that same cycle.
- Total latency is WIDTH+1 edges from the accepting edge to the visible result (33 for WIDTH=32).
- The earliest back-to-back Start is in the Done cycle, which is accepted at the edge ending that cycle.
- Busy is a registered output with no combinational path from Start. The hazard unit must also stall on Start to cover the accept cycle.
- Rst mid-operation: all state returns to reset values on the next edge regardless of FSM state.

## Structure
- Shared package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, CALC, FIX
  - ITER = WIDTH
  - counter width = $clog2(WIDTH)+1
- One sub-module, muldiv_negate: a combinational two's-complement negate parameterised on width. It is instantiated for absolute-value conversion at launch and for sign fix-up in FIX.
- The FSM, counter, and datapath live in muldiv_unit.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done exactly 33 cycles after the accepting edge, Busy high for the preceding 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (−7) ÷ 2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then DIV 0x80000000 ÷ 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 ÷ 0 -> LO=0xFFFFFFFF, HI=0x12345678, full latency. A second Start issued mid-operation is ignored (only one Done).
- After a completed op leaves HI/LO=A, launch a new op and assert Flush at cycle 10 -> Busy=0 next cycle, no Done, HI/LO still A. Repeat with Rst at cycle 20 -> HI=LO=0, Busy=0.
